// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the hardware stack bank:
//   - write-back destination codes that address the three stacks
//   - pop-id encodings driven by the stack decoder
//   - helpers that turn a code or pop-id into a one-hot stack select
//     (bit 0 = A, bit 1 = B, bit 2 = C)
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int NUM_STACKS = 3;

    localparam logic [7:0] CODE_A = 8'h20;
    localparam logic [7:0] CODE_B = 8'h40;
    localparam logic [7:0] CODE_C = 8'h60;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_A    = 2'd1,
        POP_B    = 2'd2,
        POP_C    = 2'd3
    } pop_id_e;

    // Any code other than the three stack codes addresses a general register.
    function automatic logic [NUM_STACKS-1:0] code_to_sel(input logic [7:0] code);
        case (code)
            CODE_A:  return 3'b001;
            CODE_B:  return 3'b010;
            CODE_C:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [NUM_STACKS-1:0] pop_id_to_sel(input logic [1:0] pop_id);
        case (pop_id)
            POP_A:   return 3'b001;
            POP_B:   return 3'b010;
            POP_C:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/stack_bank_if.sv
// -----------------------------------------------------------------------------
// stack_bank_if
// Bundle between the stack decoder (master) and the stack bank (slave).
//   master drives : commit strobe, pop request, write-back request
//   slave drives  : per-stack top / amount values and full, empty,
//                   overflow, underflow flag vectors (bit 0 = A, 1 = B, 2 = C)
// -----------------------------------------------------------------------------
interface stack_bank_if;

    logic        STACK_commit;
    logic        STACK_pop_flag;
    logic [1:0]  STACK_pop_id;
    logic        STACK_write_back_flag;
    logic [7:0]  STACK_write_back_code;
    logic [31:0] STACK_write_back_value;

    logic [7:0]  STACK_TOP_A;
    logic [15:0] STACK_TOP_B;
    logic [31:0] STACK_TOP_C;
    logic [7:0]  STACK_AMOUNT_A;
    logic [7:0]  STACK_AMOUNT_B;
    logic [7:0]  STACK_AMOUNT_C;
    logic [2:0]  STACK_full;
    logic [2:0]  STACK_empty;
    logic [2:0]  STACK_overflow;
    logic [2:0]  STACK_underflow;

    modport master (
        output STACK_commit, STACK_pop_flag, STACK_pop_id,
               STACK_write_back_flag, STACK_write_back_code, STACK_write_back_value,
        input  STACK_TOP_A, STACK_TOP_B, STACK_TOP_C,
               STACK_AMOUNT_A, STACK_AMOUNT_B, STACK_AMOUNT_C,
               STACK_full, STACK_empty, STACK_overflow, STACK_underflow
    );

    modport slave (
        input  STACK_commit, STACK_pop_flag, STACK_pop_id,
               STACK_write_back_flag, STACK_write_back_code, STACK_write_back_value,
        output STACK_TOP_A, STACK_TOP_B, STACK_TOP_C,
               STACK_AMOUNT_A, STACK_AMOUNT_B, STACK_AMOUNT_C,
               STACK_full, STACK_empty, STACK_overflow, STACK_underflow
    );

endinterface

// File: rtl/stack_lifo.sv
// -----------------------------------------------------------------------------
// stack_lifo
// One LIFO stack of DEPTH entries, WIDTH bits each (DEPTH 1..255).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pop_en_i, push_en_i   qualified pop / push requests for this cycle
//   push_data_i           value written on a push
//   top_o                 entry at count-1, 0 when empty (registered state only)
//   amount_o              entry count
//   full_o, empty_o       occupancy flags
//   overflow_o            sticky: push attempted while full
//   underflow_o           sticky: pop attempted while empty
// A pop and a push in the same cycle are applied pop first, then push.
// -----------------------------------------------------------------------------
module stack_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pop_en_i,
    input  logic             push_en_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [7:0]       amount_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         MEM_SIZE  = 1 << AW;
    localparam logic [7:0] DEPTH_CNT = 8'(DEPTH);

    logic [WIDTH-1:0] mem_q [MEM_SIZE];
    logic [7:0]       count_q, count_d;
    logic [7:0]       count_popped;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic             pop_ok, push_ok;
    logic             overflow_q, underflow_q;

    // The push is checked against the count left after the pop, so a
    // same-stack pop+push on a full stack replaces the top instead of
    // overflowing, and a failed pop leaves the push against the old state.
    always_comb begin
        pop_ok       = pop_en_i && (count_q != 8'd0);
        count_popped = pop_ok ? count_q - 8'd1 : count_q;
        push_ok      = push_en_i && (count_popped < DEPTH_CNT);
        count_d      = push_ok ? count_popped + 8'd1 : count_popped;
        wr_idx       = AW'(count_popped);
        rd_idx       = AW'(count_q - 8'd1);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 8'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop_en_i && !pop_ok) begin
                underflow_q <= 1'b1;
            end
            if (push_en_i && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; entries above the
    // count are never observed, and leaving it reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o       = (count_q == 8'd0) ? '0 : mem_q[rd_idx];
    assign amount_o    = count_q;
    assign full_o      = (count_q == DEPTH_CNT);
    assign empty_o     = (count_q == 8'd0);
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/stack_bank.sv
// -----------------------------------------------------------------------------
// stack_bank
// Holds hardware stacks A (8-bit), B (16-bit) and C (32-bit) of DEPTH entries.
// Ports:
//   clk, reset   clock, synchronous active-high reset (wins over commit)
//   stack_if     slave side of stack_bank_if: decoder pop / write-back
//                requests in, stack tops, amounts and flags out
// Requests take effect only on the STACK_commit cycle and are visible on all
// outputs after that edge; outputs come from registered state only, which
// keeps the decoder -> bank -> decoder loop free of combinational paths.
// -----------------------------------------------------------------------------
module stack_bank
    import stack_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    stack_bank_if.slave  stack_if
);

    logic [NUM_STACKS-1:0] pop_en;
    logic [NUM_STACKS-1:0] push_en;

    // Push is decoded from the destination code alone, independent of the
    // pop id, so a pop writing back to a stack code becomes a transfer.
    always_comb begin
        pop_en  = '0;
        push_en = '0;
        if (stack_if.STACK_commit) begin
            if (stack_if.STACK_pop_flag) begin
                pop_en = pop_id_to_sel(stack_if.STACK_pop_id);
            end
            if (stack_if.STACK_write_back_flag) begin
                push_en = code_to_sel(stack_if.STACK_write_back_code);
            end
        end
    end

    stack_lifo #(.WIDTH(8), .DEPTH(DEPTH)) u_stack_a (
        .clk         (clk),
        .reset       (reset),
        .pop_en_i    (pop_en[0]),
        .push_en_i   (push_en[0]),
        .push_data_i (stack_if.STACK_write_back_value[7:0]),
        .top_o       (stack_if.STACK_TOP_A),
        .amount_o    (stack_if.STACK_AMOUNT_A),
        .full_o      (stack_if.STACK_full[0]),
        .empty_o     (stack_if.STACK_empty[0]),
        .overflow_o  (stack_if.STACK_overflow[0]),
        .underflow_o (stack_if.STACK_underflow[0])
    );

    stack_lifo #(.WIDTH(16), .DEPTH(DEPTH)) u_stack_b (
        .clk         (clk),
        .reset       (reset),
        .pop_en_i    (pop_en[1]),
        .push_en_i   (push_en[1]),
        .push_data_i (stack_if.STACK_write_back_value[15:0]),
        .top_o       (stack_if.STACK_TOP_B),
        .amount_o    (stack_if.STACK_AMOUNT_B),
        .full_o      (stack_if.STACK_full[1]),
        .empty_o     (stack_if.STACK_empty[1]),
        .overflow_o  (stack_if.STACK_overflow[1]),
        .underflow_o (stack_if.STACK_underflow[1])
    );

    stack_lifo #(.WIDTH(32), .DEPTH(DEPTH)) u_stack_c (
        .clk         (clk),
        .reset       (reset),
        .pop_en_i    (pop_en[2]),
        .push_en_i   (push_en[2]),
        .push_data_i (stack_if.STACK_write_back_value),
        .top_o       (stack_if.STACK_TOP_C),
        .amount_o    (stack_if.STACK_AMOUNT_C),
        .full_o      (stack_if.STACK_full[2]),
        .empty_o     (stack_if.STACK_empty[2]),
        .overflow_o  (stack_if.STACK_overflow[2]),
        .underflow_o (stack_if.STACK_underflow[2])
    );

endmodule
